instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 30 +++
 rtl/instr_fetch.sv | 95 +++++++++
 tb/tb_instr_fetch.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: sequencing controls and decoder feedback in, PC/instruction/status out.
// The slave modport is the fetch unit; the master modport is the core/memory side driving it.
interface instr_fetch_if #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 9,
  parameter int CNT_WIDTH   = 16
);
  logic                   Start;
  logic                   Stall;
  logic                   Branch;
  logic                   BranchTaken;
  logic [PC_WIDTH-1:0]    Target;
  logic                   Halt;
  logic [INSTR_WIDTH-1:0] InstrIn;
  logic [PC_WIDTH-1:0]    InstrAddr;
  logic [INSTR_WIDTH-1:0] Instr;
  logic                   InstrValid;
  logic                   Done;
  logic [CNT_WIDTH-1:0]   CycleCount;

  modport master (
    output Start, Stall, Branch, BranchTaken, Target, Halt, InstrIn,
    input  InstrAddr, Instr, InstrValid, Done, CycleCount
  );

  modport slave (
    input  Start, Stall, Branch, BranchTaken, Target, Halt, InstrIn,
    output InstrAddr, Instr, InstrValid, Done, CycleCount
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: PC drives memory, Instr registered one cycle later; taken branch costs one flush cycle.
// Stall freezes PC/Instr/InstrValid for the cycle; Start restarts from PC 0 with priority over everything else.
module instr_fetch #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 9,
  parameter int CNT_WIDTH   = 16
) (
  input  logic         Clk,
  input  logic         Reset_n,
  instr_fetch_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [PC_WIDTH-1:0]  PC_ONE  = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   vld_q, vld_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.Start) begin
          state_d = S_RUN;
          pc_d    = '0;
          vld_d   = 1'b0;
          cnt_d   = '0;
        end
      end

      S_RUN: begin
        if (bus.Start) begin
          pc_d  = '0;
          vld_d = 1'b0;
          cnt_d = '0;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
          // Decoder flags only mean something when Instr holds a real instruction.
          if (!bus.Stall) begin
            if (vld_q && bus.Halt) begin
              state_d = S_DONE;
              vld_d   = 1'b0;
            end else if (vld_q && bus.Branch && bus.BranchTaken) begin
              pc_d  = bus.Target;
              vld_d = 1'b0;
            end else begin
              instr_d = bus.InstrIn;
              vld_d   = 1'b1;
              pc_d    = pc_q + PC_ONE;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.InstrAddr  = pc_q;
  assign bus.Instr      = instr_q;
  assign bus.InstrValid = vld_q;
  assign bus.Done       = (state_q == S_DONE);
  assign bus.CycleCount = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes hand-computed post-edge expectations, a negedge monitor pops and compares.
// dut_a uses default widths; dut_b (PC_WIDTH=4, CNT_WIDTH=4) covers PC wrap and counter saturation.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_if #(.PC_WIDTH(10), .INSTR_WIDTH(9), .CNT_WIDTH(16)) ifa ();
  instr_fetch_if #(.PC_WIDTH(4),  .INSTR_WIDTH(9), .CNT_WIDTH(4))  ifb ();

  instr_fetch #(.PC_WIDTH(10), .INSTR_WIDTH(9), .CNT_WIDTH(16)) dut_a (
    .Clk(clk), .Reset_n(rst_n), .bus(ifa.slave)
  );
  instr_fetch #(.PC_WIDTH(4), .INSTR_WIDTH(9), .CNT_WIDTH(4)) dut_b (
    .Clk(clk), .Reset_n(rst_n), .bus(ifb.slave)
  );

  // ROM[n] = n
  assign ifa.InstrIn = ifa.InstrAddr[8:0];
  assign ifb.InstrIn = {5'b0, ifb.InstrAddr};

  typedef struct {
    bit          sel;
    string       tag;
    logic [31:0] addr;
    logic [31:0] instr;
    bit          chk_instr;
    bit          vld;
    bit          done;
    logic [31:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      if (!e.sel) begin
        check({e.tag, ".addr"}, 32'(ifa.InstrAddr), e.addr);
        if (e.chk_instr) check({e.tag, ".instr"}, 32'(ifa.Instr), e.instr);
        check({e.tag, ".vld"},  32'(ifa.InstrValid), 32'(e.vld));
        check({e.tag, ".done"}, 32'(ifa.Done), 32'(e.done));
        check({e.tag, ".cnt"},  32'(ifa.CycleCount), e.cnt);
      end else begin
        check({e.tag, ".addr"}, 32'(ifb.InstrAddr), e.addr);
        if (e.chk_instr) check({e.tag, ".instr"}, 32'(ifb.Instr), e.instr);
        check({e.tag, ".vld"},  32'(ifb.InstrValid), 32'(e.vld));
        check({e.tag, ".done"}, 32'(ifb.Done), 32'(e.done));
        check({e.tag, ".cnt"},  32'(ifb.CycleCount), e.cnt);
      end
    end
  end

  task automatic push(bit sel, string tag, int ea, int ei, bit ev, bit ed, int ec, bit ci);
    exp_t e;
    e.sel = sel; e.tag = tag; e.addr = ea; e.instr = ei; e.chk_instr = ci;
    e.vld = ev; e.done = ed; e.cnt = ec;
    sbq.push_back(e);
  endtask

  // One clock on dut_a: apply inputs, clock, then queue the state expected after that edge.
  task automatic cyc(string tag, bit st, bit sl, bit br, bit tk, logic [9:0] tgt, bit hl,
                     int ea, int ei, bit ev, bit ed, int ec, bit ci = 1'b1);
    ifa.Start = st; ifa.Stall = sl; ifa.Branch = br; ifa.BranchTaken = tk;
    ifa.Target = tgt; ifa.Halt = hl;
    @(posedge clk); #1;
    push(1'b0, tag, ea, ei, ev, ed, ec, ci);
  endtask

  task automatic check_a_zero(string tag);
    check({tag, ".addr"},  32'(ifa.InstrAddr), 0);
    check({tag, ".instr"}, 32'(ifa.Instr), 0);
    check({tag, ".vld"},   32'(ifa.InstrValid), 0);
    check({tag, ".done"},  32'(ifa.Done), 0);
    check({tag, ".cnt"},   32'(ifa.CycleCount), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ifa.Start = 0; ifa.Stall = 0; ifa.Branch = 0; ifa.BranchTaken = 0; ifa.Target = '0; ifa.Halt = 0;
    ifb.Start = 0; ifb.Stall = 0; ifb.Branch = 0; ifb.BranchTaken = 0; ifb.Target = '0; ifb.Halt = 0;
    #12;
    check_a_zero("reset");
    check("reset_b.addr", 32'(ifb.InstrAddr), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle holds, then sequential fetch
    cyc("idle",   0,0,0,0,10'h0,0,  0,0,0,0,0);
    cyc("start",  1,0,0,0,10'h0,0,  0,0,0,0,0);
    cyc("seq1",   0,0,0,0,10'h0,0,  1,0,1,0,1);
    cyc("seq2",   0,0,0,0,10'h0,0,  2,1,1,0,2);
    cyc("seq3",   0,0,0,0,10'h0,0,  3,2,1,0,3);
    cyc("seq4",   0,0,0,0,10'h0,0,  4,3,1,0,4);
    cyc("seq5",   0,0,0,0,10'h0,0,  5,4,1,0,5);
    cyc("seq6",   0,0,0,0,10'h0,0,  6,5,1,0,6);
    // Taken branch while Instr=ROM[5]: one flush cycle
    cyc("br_tk",  0,0,1,1,10'h040,0, 'h40,0,0,0,7, 0);
    cyc("br_t1",  0,0,0,0,10'h0,0,  'h41,'h40,1,0,8);
    cyc("br_t2",  0,0,0,0,10'h0,0,  'h42,'h41,1,0,9);
    cyc("br_nt",  0,0,1,0,10'h100,0,'h43,'h42,1,0,10);
    // Start in RUN beats Stall/Halt; then Branch/Halt ignored while InstrValid=0
    cyc("rstart", 1,1,0,0,10'h0,1,  0,'h42,0,0,0);
    cyc("ign_v0", 0,0,1,1,10'h055,1, 1,0,1,0,1);
    cyc("s2",     0,0,0,0,10'h0,0,  2,1,1,0,2);
    cyc("s3",     0,0,0,0,10'h0,0,  3,2,1,0,3);
    cyc("s4",     0,0,0,0,10'h0,0,  4,3,1,0,4);
    cyc("s5",     0,0,0,0,10'h0,0,  5,4,1,0,5);
    cyc("s6",     0,0,0,0,10'h0,0,  6,5,1,0,6);
    cyc("s7",     0,0,0,0,10'h0,0,  7,6,1,0,7);
    // Stall 3 cycles at PC=7 with Branch/Halt asserted (must be ignored)
    cyc("stall1", 0,1,1,1,10'h020,1, 7,6,1,0,8);
    cyc("stall2", 0,1,1,1,10'h020,1, 7,6,1,0,9);
    cyc("stall3", 0,1,1,1,10'h020,1, 7,6,1,0,10);
    cyc("unstal", 0,0,0,0,10'h0,0,  8,7,1,0,11);
    // Halt together with taken branch: Halt wins
    cyc("halt",   0,0,1,1,10'h030,1, 8,7,0,1,12);
    cyc("done_h", 0,1,1,1,10'h030,1, 8,7,0,1,12);
    cyc("dstart", 1,0,0,0,10'h0,0,  0,7,0,0,0);
    cyc("r1",     0,0,0,0,10'h0,0,  1,0,1,0,1);
    cyc("r2",     0,0,0,0,10'h0,0,  2,1,1,0,2);
    cyc("r3",     0,0,0,0,10'h0,0,  3,2,1,0,3);
    cyc("r4",     0,0,0,0,10'h0,0,  4,3,1,0,4);
    cyc("r5",     0,0,0,0,10'h0,0,  5,4,1,0,5);
    cyc("r6",     0,0,0,0,10'h0,0,  6,5,1,0,6);
    cyc("r7",     0,0,0,0,10'h0,0,  7,6,1,0,7);
    cyc("r8",     0,0,0,0,10'h0,0,  8,7,1,0,8);
    cyc("r9",     0,0,0,0,10'h0,0,  9,8,1,0,9);

    // Async reset between edges at PC=9
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_a_zero("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("post_idle",  0,0,0,0,10'h0,0, 0,0,0,0,0);
    cyc("post_start", 1,0,0,0,10'h0,0, 0,0,0,0,0);
    cyc("post_r1",    0,0,0,0,10'h0,0, 1,0,1,0,1);
    ifa.Start = 0;

    // PC wrap and counter saturation on the narrow instance
    ifb.Start = 1'b1;
    @(posedge clk); #1;
    push(1'b1, "wrap_start", 0, 0, 1'b0, 1'b0, 0, 1'b1);
    ifb.Start = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      push(1'b1, $sformatf("wrap%0d", k), k % 16, (k - 1) % 16, 1'b1, 1'b0, (k > 15) ? 15 : k, 1'b1);
    end

    repeat (2) @(negedge clk);
    #1;
    check("sb_drained", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
